// File: rtl/hja_seg_disp_pkg.sv
// Shared types and constants for the hex-digit debug display.
package hja_seg_disp_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HIGH = 2'd1,
    HELD      = 2'd2,
    WAIT_LOW  = 2'd3
  } db_state_e;

  // Active-high segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1101111;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b1111100;
  localparam logic [6:0] SEG_C = 7'b0111001;
  localparam logic [6:0] SEG_D = 7'b1011110;
  localparam logic [6:0] SEG_E = 7'b1111001;
  localparam logic [6:0] SEG_F = 7'b1110001;

  localparam logic [15:0][6:0] SEG_LUT = {
    SEG_F, SEG_E, SEG_D, SEG_C,
    SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4,
    SEG_3, SEG_2, SEG_1, SEG_0
  };

endpackage

// File: rtl/hja_seg_disp_hex7seg.sv
// Combinational nibble to seven-segment decoder.
module hja_hex7seg
  import hja_seg_disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[nib];

endmodule

// File: rtl/hja_seg_disp.sv
// Two-digit hex display of a 16-bit debug word, paging bytes.
// Freeze button support is built only with HJA_SEG_FREEZE_EN.
module hja_seg_disp
  import hja_seg_disp_pkg::*;
#(
  parameter int DWELL     = 50000000,
  parameter int DB_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] led_data,
  input  logic        freeze_btn,
  output logic [6:0]  seg_hi,
  output logic [6:0]  seg_lo,
  output logic        byte_sel,
  output logic        frozen
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] DW_LAST = DW'(DWELL - 1);

  logic [15:0]   snap;
  logic [DW-1:0] dwell_cnt;
  logic [7:0]    shown;
  logic [6:0]    dec_hi;
  logic [6:0]    dec_lo;
  logic          frozen_q;

`ifdef HJA_SEG_FREEZE_EN
  localparam int BW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [BW-1:0] DB_LAST = BW'(DB_CYCLES - 1);

  logic          sync1;
  logic          btn_s;
  db_state_e     state;
  db_state_e     state_nxt;
  logic [BW-1:0] db_cnt;
  logic [BW-1:0] db_cnt_nxt;
  logic          toggle;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      sync1 <= freeze_btn;
      btn_s <= sync1;
    end
  end

  always_comb begin
    state_nxt  = state;
    db_cnt_nxt = db_cnt + BW'(1);
    toggle     = 1'b0;
    unique case (state)
      IDLE: begin
        db_cnt_nxt = '0;
        if (btn_s) state_nxt = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (!btn_s) begin
          state_nxt  = IDLE;
          db_cnt_nxt = '0;
        end else if (db_cnt == DB_LAST) begin
          state_nxt  = HELD;
          db_cnt_nxt = '0;
          toggle     = 1'b1;
        end
      end
      HELD: begin
        db_cnt_nxt = '0;
        if (!btn_s) state_nxt = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (btn_s) begin
          state_nxt  = HELD;
          db_cnt_nxt = '0;
        end else if (db_cnt == DB_LAST) begin
          state_nxt  = IDLE;
          db_cnt_nxt = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      db_cnt   <= '0;
      frozen_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      db_cnt   <= db_cnt_nxt;
      frozen_q <= frozen_q ^ toggle;
    end
  end
`else
  logic unused_btn;
  assign unused_btn = freeze_btn;
  assign frozen_q   = 1'b0;
`endif

  assign shown = byte_sel ? snap[15:8] : snap[7:0];

  hja_hex7seg u_dec_hi (
    .nib (shown[7:4]),
    .seg (dec_hi)
  );

  hja_hex7seg u_dec_lo (
    .nib (shown[3:0]),
    .seg (dec_lo)
  );

  // snap samples on the freezing edge too, since frozen_q is still 0 there
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap      <= '0;
      dwell_cnt <= '0;
      byte_sel  <= 1'b0;
      seg_hi    <= SEG_0;
      seg_lo    <= SEG_0;
    end else begin
      if (!frozen_q) snap <= led_data;
      if (dwell_cnt == DW_LAST) begin
        dwell_cnt <= '0;
        byte_sel  <= ~byte_sel;
      end else begin
        dwell_cnt <= dwell_cnt + DW'(1);
      end
      seg_hi <= dec_hi;
      seg_lo <= dec_lo;
    end
  end

  assign frozen = frozen_q;

endmodule

// File: tb/tb_hja_seg_disp.sv
// Directed self-checking bench for hja_seg_disp (DWELL=4, DB_CYCLES=3).
module tb_hja_seg_disp;

  logic        clk;
  logic        rst;
  logic [15:0] led_data;
  logic        freeze_btn;
  logic [6:0]  seg_hi;
  logic [6:0]  seg_lo;
  logic        byte_sel;
  logic        frozen;

  int checks;
  int errors;
  int cyc;

  logic [6:0] tbl [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  hja_seg_disp #(
    .DWELL     (4),
    .DB_CYCLES (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .led_data   (led_data),
    .freeze_btn (freeze_btn),
    .seg_hi     (seg_hi),
    .seg_lo     (seg_lo),
    .byte_sel   (byte_sel),
    .frozen     (frozen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // edges since reset release
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // byte_sel flips every 4 edges; segments lag byte_sel by one edge
  task automatic check_disp(input string tag, input logic [15:0] v);
    logic       eb;
    logic       sb;
    logic [7:0] b;
    eb = ((cyc / 4) % 2) == 1;
    sb = (((cyc - 1) / 4) % 2) == 1;
    b  = sb ? v[15:8] : v[7:0];
    chk({tag, "_bsel"}, {15'd0, byte_sel}, {15'd0, eb});
    chk({tag, "_hi"}, {9'd0, seg_hi}, {9'd0, tbl[b[7:4]]});
    chk({tag, "_lo"}, {9'd0, seg_lo}, {9'd0, tbl[b[3:0]]});
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b0;
    led_data   = 16'h0000;
    freeze_btn = 1'b0;
    tick(2);
    chk("rst_seg_hi", {9'd0, seg_hi}, 16'h003F);
    chk("rst_seg_lo", {9'd0, seg_lo}, 16'h003F);
    chk("rst_bsel", {15'd0, byte_sel}, 16'h0000);
    chk("rst_frozen", {15'd0, frozen}, 16'h0000);

    led_data = 16'h12AB;
    rst      = 1'b1;
    tick(2);
    chk("first_hi", {9'd0, seg_hi}, {9'd0, 7'b1110111});
    chk("first_lo", {9'd0, seg_lo}, {9'd0, 7'b1111100});
    chk("first_bsel", {15'd0, byte_sel}, 16'h0000);
    tick(4);
    chk("page_hi", {9'd0, seg_hi}, {9'd0, 7'b0000110});
    chk("page_lo", {9'd0, seg_lo}, {9'd0, 7'b1011011});
    chk("page_bsel", {15'd0, byte_sel}, 16'h0001);

`ifdef HJA_SEG_FREEZE_EN
    freeze_btn = 1'b1;
    tick(1);
    freeze_btn = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("glitch_frozen", {15'd0, frozen}, 16'h0000);
    end
    led_data = 16'h3456;
    tick(1);
    check_disp("lat_old", 16'h12AB);
    tick(1);
    check_disp("lat_new", 16'h3456);

    led_data = 16'h00FF;
    tick(2);
    freeze_btn = 1'b1;
    tick(5);
    chk("press_pre", {15'd0, frozen}, 16'h0000);
    tick(1);
    chk("press_set", {15'd0, frozen}, 16'h0001);
    led_data = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      tick(2);
      check_disp("hold", 16'h00FF);
    end
    freeze_btn = 1'b0;
    tick(8);
    chk("release_frozen", {15'd0, frozen}, 16'h0001);
    check_disp("release", 16'h00FF);
    freeze_btn = 1'b1;
    tick(5);
    chk("unpress_pre", {15'd0, frozen}, 16'h0001);
    tick(1);
    chk("unpress_clr", {15'd0, frozen}, 16'h0000);
    tick(2);
    check_disp("unfrozen", 16'h0000);

    freeze_btn = 1'b0;
    tick(8);
    freeze_btn = 1'b1;
    tick(6);
    chk("refreeze", {15'd0, frozen}, 16'h0001);
    freeze_btn = 1'b0;
    tick(8);
    freeze_btn = 1'b1;
    tick(3);
    rst = 1'b0;
    #1;
    chk("arst_frozen", {15'd0, frozen}, 16'h0000);
    chk("arst_bsel", {15'd0, byte_sel}, 16'h0000);
    chk("arst_hi", {9'd0, seg_hi}, 16'h003F);
    chk("arst_lo", {9'd0, seg_lo}, 16'h003F);
    tick(2);
    led_data = 16'hBEEF;
    rst      = 1'b1;
    tick(1);
    freeze_btn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("post_rst_frozen", {15'd0, frozen}, 16'h0000);
    end
    check_disp("post_rst", 16'hBEEF);
`else
    freeze_btn = 1'b1;
    led_data   = 16'h0001;
    tick(1);
    check_disp("nf_old", 16'h12AB);
    tick(1);
    check_disp("nf_one", 16'h0001);
    led_data = 16'h0002;
    tick(1);
    check_disp("nf_lag", 16'h0001);
    tick(1);
    check_disp("nf_two", 16'h0002);
    for (int i = 0; i < 16; i++) begin
      tick(1);
      chk("nf_frozen", {15'd0, frozen}, 16'h0000);
    end
    check_disp("nf_end", 16'h0002);
    freeze_btn = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
